spi_wb_bridge: RTL

SPI_WB_BRIDGE -- requirements
Module: spi_wb_bridge

---
 rtl/spi_wb_bridge.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 slave to Wishbone master: 0x02 writes 4 bytes, 0x03 reads 4 bytes after one dummy byte.
// Latency: the bus cycle starts one clk after the last write bit or the last address bit; the host is stalled only by the dummy byte (0xFF on underrun).
module spi_wb_bridge #(
    parameter int WB_AW = 16,
    parameter int WB_DW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_sck,
    input  logic             spi_csn,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    output logic [WB_AW-1:0] wb_addr,
    output logic [WB_DW-1:0] wb_wdata,
    input  logic [WB_DW-1:0] wb_rdata,
    output logic             wb_we,
    output logic             wb_cyc,
    input  logic             wb_ack
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WDATA, WB_CYC, DUMMY, RDATA, IGNORE
    } state_t;

    logic sck_s1_q, sck_s2_q, sck_h_q;
    logic csn_s1_q, csn_s2_q, csn_h_q;
    logic mosi_s1_q, mosi_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_h_q   <= 1'b0;
            csn_s1_q  <= 1'b1;
            csn_s2_q  <= 1'b1;
            csn_h_q   <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= spi_sck;
            sck_s2_q  <= sck_s1_q;
            sck_h_q   <= sck_s2_q;
            csn_s1_q  <= spi_csn;
            csn_s2_q  <= csn_s1_q;
            csn_h_q   <= csn_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    logic sck_rise, sck_fall, csn_fall;
    assign sck_rise = sck_s2_q & ~sck_h_q;
    assign sck_fall = ~sck_s2_q & sck_h_q;
    assign csn_fall = ~csn_s2_q & csn_h_q;

    state_t           state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [6:0]       rx_q, rx_d;
    logic [WB_AW-1:0] addr_q, addr_d;
    logic [WB_DW-1:0] wdata_q, wdata_d;
    logic [WB_DW-1:0] rd_sh_q, rd_sh_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             underrun_q, underrun_d;
    logic             miso_q, miso_d;
    logic             pend_q, pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            byte_q     <= '0;
            rx_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_sh_q    <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            underrun_q <= 1'b0;
            miso_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            rx_q       <= rx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_sh_q    <= rd_sh_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            underrun_q <= underrun_d;
            miso_q     <= miso_d;
            pend_q     <= pend_d;
        end
    end

    logic       bit_last;
    logic [7:0] cmd_byte;
    assign bit_last = (bit_q == 3'd7);
    assign cmd_byte = {rx_q, mosi_s2_q};

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_sh_d    = rd_sh_q;
        we_d       = we_q;
        cyc_d      = cyc_q & ~wb_ack;
        underrun_d = underrun_q;
        miso_d     = miso_q;
        pend_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A frame that opens while an abandoned cycle is still running waits for its ack.
                pend_d = (pend_q | csn_fall) & cyc_q & ~csn_s2_q;
                if ((csn_fall | pend_q) && !cyc_q && !csn_s2_q) begin
                    state_d    = CMD;
                    bit_d      = '0;
                    byte_d     = '0;
                    underrun_d = 1'b0;
                end
            end
            CMD: if (sck_rise) begin
                rx_d  = {rx_q[5:0], mosi_s2_q};
                bit_d = bit_q + 3'd1;
                if (bit_last) begin
                    byte_d = '0;
                    if (cmd_byte == 8'h02 || cmd_byte == 8'h03) begin
                        state_d = ADDR;
                        we_d    = (cmd_byte == 8'h02);
                    end else begin
                        state_d = IGNORE;
                    end
                end
            end
            ADDR: if (sck_rise) begin
                addr_d = {addr_q[WB_AW-2:0], mosi_s2_q};
                bit_d  = bit_q + 3'd1;
                if (bit_last) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd1) begin
                        byte_d  = '0;
                        state_d = we_q ? WDATA : WB_CYC;
                        cyc_d   = ~we_q;
                    end
                end
            end
            WDATA: if (sck_rise) begin
                wdata_d = {wdata_q[WB_DW-2:0], mosi_s2_q};
                bit_d   = bit_q + 3'd1;
                if (bit_last) begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = WB_CYC;
                        cyc_d   = 1'b1;
                    end
                end
            end
            WB_CYC: begin
                if (we_q) begin
                    if (wb_ack) state_d = IGNORE;
                end else begin
                    // The dummy byte keeps clocking while the read is outstanding.
                    if (sck_rise) bit_d = bit_q + 3'd1;
                    if (wb_ack) begin
                        rd_sh_d = wb_rdata;
                        byte_d  = '0;
                        state_d = (sck_rise && bit_last) ? RDATA : DUMMY;
                    end else if (sck_rise && bit_last) begin
                        underrun_d = 1'b1;
                        byte_d     = '0;
                        state_d    = RDATA;
                    end
                end
            end
            DUMMY: if (sck_rise) begin
                bit_d = bit_q + 3'd1;
                if (bit_last) begin
                    byte_d  = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (sck_fall) begin
                    miso_d  = underrun_q | rd_sh_q[WB_DW-1];
                    rd_sh_d = {rd_sh_q[WB_DW-2:0], 1'b0};
                end
                if (sck_rise) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_last) begin
                        byte_d = byte_q + 2'd1;
                        if (byte_q == 2'd3) state_d = IGNORE;
                    end
                end
            end
            default: ;
        endcase

        if (state_q != IDLE && csn_s2_q) state_d = IDLE;
        if (state_d != RDATA) miso_d = 1'b0;
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = ~csn_s2_q;
    assign wb_addr     = addr_q;
    assign wb_wdata    = wdata_q;
    assign wb_we       = we_q;
    assign wb_cyc      = cyc_q;

endmodule
